prog_loader: RTL
================

# prog_loader

Byte-stream program loader that fills the instruction memory read by the core's fetch stage. It accepts a framed stream of bytes from a host-side link and writes 9-bit machine-code words into instruction memory at sequential addresses. It holds the core in reset until a complete frame with a valid checksum has been written. It sits between the host link and the instruction memory write port, alongside `top_level`.

## Interface
- `D`, 10, instruction address width. It matches the program counter width. Legal range is 9..16.

- `clk`  in  1  clock; every register updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle re-arm request; it aborts any load in progress.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `im_wr_en`  out  1  instruction memory write strobe.
- `im_wr_addr`  out  D  instruction memory write address.
- `im_wr_data`  out  9  machine-code word.
- `core_hold`  out  1  keeps the core in reset.
- `load_done`  out  1  level signal: load completed, checksum good.
- `load_err`  out  1  level signal: load failed.

## Operation
- **Frame, in order:** CNT_LO, CNT_HI, then N × (INS_LO, INS_HI), then CHK.
  - N = {CNT_HI[D-9:0], CNT_LO}.
  - Word = {INS_HI[0], INS_LO}.
  - CHK = XOR of every preceding byte in the frame.
- **Handshake:** a byte is accepted on an edge where `in_valid && in_ready`. At most one byte is accepted per cycle. `in_valid` gaps of any length are legal.
- **FSM states:** S_CLO, S_CHI, S_ILO, S_IHI, S_CHK, S_DONE, S_ERR.
  - S_CLO: accept → S_CHI.
  - S_CHI: CNT_HI[7:D-8] ≠ 0 → S_ERR. Otherwise latch N. N=0 → S_CHK, else → S_ILO.
  - S_ILO: accept → S_IHI (latch low byte).
  - S_IHI: INS_HI[7:1] ≠ 0 → S_ERR with no write. Otherwise issue a write; addr+1; if addr+1 == N → S_CHK, else → S_ILO.
  - S_CHK: byte == running XOR → S_DONE, else → S_ERR.
  - S_DONE and S_ERR hold until `start` or reset.
- **Running XOR:** 8-bit. Cleared on entry to S_CLO. Updated with every accepted byte except CHK.
- **Address counter:** D bits. Cleared on entry to S_CLO. Maximum loadable N is 2^D−1; there is no wrap.
- **`in_ready`:** 1 in S_CLO..S_CHK when `start`=0. 0 in S_DONE and S_ERR, and in any cycle where `start`=1.
- **`start`:** from any state → S_CLO on the next edge. Clears `load_done`/`load_err`, asserts `core_hold`, and clears the XOR and the address. No byte is accepted in that cycle.
- **Outputs by state:**
  - `core_hold` = 0 only in S_DONE.
  - `load_done` = 1 only in S_DONE.
  - `load_err` = 1 only in S_ERR.
- **Errors:** memory writes already issued before an error are not undone.

## Timing
- **Reset values** (asynchronous, while `reset`=0): state S_CLO, `core_hold`=1, `load_done`=0, `load_err`=0, `im_wr_en`=0, `im_wr_addr`=0, `im_wr_data`=0, XOR=0, N=0.
  - `in_ready`=1 from the first cycle after deassertion.
- **Write latency:** `im_wr_en`, `im_wr_addr` and `im_wr_data` are registered. They are valid for exactly one cycle, the cycle after the edge that accepted INS_HI. `im_wr_data` and `im_wr_addr` hold their last values otherwise.
- **Completion:** `load_done`/`load_err` rise, and `core_hold` falls, in the cycle after the edge accepting the deciding byte.
- **Minimum load time:** 2N+3 cycles with `in_valid` held high.
- **Reset mid-frame:** returns to S_CLO immediately and aborts any pending write (`im_wr_en`=0). The frame must be resent from CNT_LO.

## Test plan
- **Good load, D=10:** stream 02,00,A5,01,03,00,A5 with `in_valid` held high. Required: writes addr0=0x1A5 then addr1=0x003, each a one-cycle strobe. `load_done`=1 and `core_hold`=0 one cycle after the CHK byte.
- **Empty program:** stream 00,00,00. Required: no `im_wr_en`; `load_done`=1 after the 3rd byte.
- **Bad checksum:** stream 02,00,A5,01,03,00,FF. Required: both writes occur, then `load_err`=1, `core_hold` stays 1, `in_ready`=0.
- **Field errors:**
  - CNT_HI=0x04 → `load_err` after byte 2, with no writes.
  - Frame 01,00,12,02 → `load_err` after byte 4, with no write.
- **Backpressure and restart:** repeat the good-load frame with `in_valid` low on alternate cycles. Required: identical writes and result. Then pulse `start` while in S_DONE. Required: `load_done`=0, `core_hold`=1, `in_ready`=0 in the pulse cycle, then a new frame loads.
- **Abort:**
  - `start` pulsed after byte 3 of the good-load frame, followed by a full frame 01,00,7F,00,7E → single write addr0=0x07F, then `load_done`.
  - `reset` asserted after byte 4 → all outputs at their reset values, no further writes.

Source files
------------

// File: rtl/prog_loader.sv
// Framed byte-stream loader: CNT_LO, CNT_HI, N x (INS_LO, INS_HI), CHK.
// Writes 9-bit words to instruction memory and holds the core until a checksummed frame lands.
module prog_loader #(
  parameter int D = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         im_wr_en,
  output logic [D-1:0] im_wr_addr,
  output logic [8:0]   im_wr_data,
  output logic         core_hold,
  output logic         load_done,
  output logic         load_err
);

  typedef enum logic [2:0] {
    S_CLO,
    S_CHI,
    S_ILO,
    S_IHI,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [D-1:0] ONE = {{(D-1){1'b0}}, 1'b1};

  state_t       state, state_nxt;
  logic [7:0]   cnt_lo, ins_lo, xsum;
  logic [D-1:0] n_words, addr;
  logic [15:0]  cnt_full;
  logic         cnt_bad, ins_bad, last_word;
  logic         acc_p0, vld_p0;
  logic         vld_p1;
  logic [D-1:0] addr_p1;
  logic [8:0]   data_p1;

  assign cnt_full  = {in_data, cnt_lo};
  assign cnt_bad   = (cnt_full >> D) != 16'd0;
  assign ins_bad   = in_data[7:1] != 7'd0;
  assign last_word = (addr == (n_words - ONE));

  assign in_ready  = !start && (state != S_DONE) && (state != S_ERR);
  assign acc_p0    = in_valid && in_ready;

  // start overrides the status outputs in its own cycle so the core is held immediately
  assign core_hold = start || (state != S_DONE);
  assign load_done = !start && (state == S_DONE);
  assign load_err  = !start && (state == S_ERR);

  assign im_wr_en   = vld_p1;
  assign im_wr_addr = addr_p1;
  assign im_wr_data = data_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_CLO;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    vld_p0    = 1'b0;
    if (start) begin
      state_nxt = S_CLO;
    end else if (acc_p0) begin
      case (state)
        S_CLO: state_nxt = S_CHI;
        S_CHI: begin
          if (cnt_bad) begin
            state_nxt = S_ERR;
          end else if (cnt_full[D-1:0] == '0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_ILO;
          end
        end
        S_ILO: state_nxt = S_IHI;
        S_IHI: begin
          if (ins_bad) begin
            state_nxt = S_ERR;
          end else begin
            vld_p0    = 1'b1;
            state_nxt = last_word ? S_CHK : S_ILO;
          end
        end
        S_CHK:   state_nxt = (in_data == xsum) ? S_DONE : S_ERR;
        default: state_nxt = state;
      endcase
    end
  end

  // p0 -> p1: accepted INS_HI becomes a one-cycle registered memory write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
      xsum    <= '0;
      addr    <= '0;
      n_words <= '0;
      cnt_lo  <= '0;
      ins_lo  <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= addr;
        data_p1 <= {in_data[0], ins_lo};
      end
      if (start) begin
        xsum    <= '0;
        addr    <= '0;
        n_words <= '0;
      end else if (acc_p0) begin
        if (state != S_CHK) begin
          xsum <= xsum ^ in_data;
        end
        case (state)
          S_CLO:   cnt_lo  <= in_data;
          S_CHI:   n_words <= cnt_full[D-1:0];
          S_ILO:   ins_lo  <= in_data;
          S_IHI: begin
            if (vld_p0) begin
              addr <= addr + ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
